// File: rtl/mac_ctrl_pkg.sv
// Shared types and defaults for the MAC sequencer: state encoding, default widths
// and the number of drain cycles matching the MAC's internal pipeline depth.
package mac_ctrl_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int LEN_WIDTH_DEF  = 8;

    // Edges needed after the last operand pair before mac_cout holds the full sum.
    localparam int DRAIN_CYCLES = 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_STREAM  = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_RESULT  = 3'd5
    } state_e;

endpackage

// File: rtl/mac_seq_ctrl.sv
// Dot-product job sequencer: clears the MAC, streams operand pairs into it, drains the
// product pipeline, captures the accumulator and offers it on a valid/ready port.
module mac_seq_ctrl
    import mac_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int LEN_WIDTH  = LEN_WIDTH_DEF,
    parameter int ACC_WIDTH  = DATA_WIDTH * 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic                  abort,
    output logic                  busy,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic [DATA_WIDTH-1:0] b_in,
    output logic                  mac_en,
    output logic                  mac_clr,
    output logic [DATA_WIDTH-1:0] mac_a,
    output logic [DATA_WIDTH-1:0] mac_b,
    input  logic [ACC_WIDTH-1:0]  mac_cout,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [ACC_WIDTH-1:0]  res_data
);

    localparam int DRW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRW-1:0] DRAIN_LAST = DRW'(DRAIN_CYCLES - 1);

    state_e                state_q, state_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic [DRW-1:0]        drain_q, drain_d;
    logic [ACC_WIDTH-1:0]  res_data_q, res_data_d;
    logic                  abort_job;

    assign abort_job = abort && (state_q != ST_IDLE);
    assign res_data  = res_data_q;

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values computed by the combinational processes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rem_q      <= '0;
            drain_q    <= '0;
            res_data_q <= '0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            drain_q    <= drain_d;
            res_data_q <= res_data_d;
        end
    end

    // NOTE: every variable gets a hold/default value before the case so no path
    // through this block leaves one unassigned, which would infer a latch.
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        drain_d    = drain_q;
        res_data_d = res_data_q;
        if (abort_job) begin
            state_d = ST_IDLE;
            rem_d   = '0;
            drain_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start && !abort) begin
                        rem_d   = len;
                        state_d = ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    drain_d = '0;
                    // A zero-length job leaves the cleared accumulator untouched.
                    state_d = (rem_q != '0) ? ST_STREAM : ST_CAPTURE;
                end
                ST_STREAM: begin
                    if (in_valid && in_ready) begin
                        rem_d = rem_q - LEN_WIDTH'(1);
                        if (rem_q == LEN_WIDTH'(1)) begin
                            state_d = ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_q == DRAIN_LAST) begin
                        drain_d = '0;
                        state_d = ST_CAPTURE;
                    end else begin
                        drain_d = drain_q + DRW'(1);
                    end
                end
                ST_CAPTURE: begin
                    res_data_d = mac_cout;
                    state_d    = ST_RESULT;
                end
                ST_RESULT: begin
                    if (res_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (state_q != ST_IDLE);
        in_ready  = 1'b0;
        mac_en    = 1'b0;
        mac_clr   = 1'b0;
        mac_a     = '0;
        mac_b     = '0;
        res_valid = 1'b0;
        if (abort_job) begin
            mac_clr = 1'b1;
        end else begin
            unique case (state_q)
                ST_CLEAR:  mac_clr = 1'b1;
                ST_STREAM: begin
                    in_ready = 1'b1;
                    mac_en   = in_valid;
                    // Zero operands on stalls keep the MAC inputs quiet.
                    mac_a    = in_valid ? a_in : '0;
                    mac_b    = in_valid ? b_in : '0;
                end
                ST_DRAIN:  mac_en    = 1'b1;
                ST_RESULT: res_valid = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl driving a behavioural registered-product MAC.
module tb_mac_seq_ctrl;

    localparam int DW = 8;
    localparam int LW = 8;
    localparam int AW = 24;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [LW-1:0] len;
    logic          abort;
    logic          busy;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] a_in;
    logic [DW-1:0] b_in;
    logic          mac_en;
    logic          mac_clr;
    logic [DW-1:0] mac_a;
    logic [DW-1:0] mac_b;
    logic [AW-1:0] mac_cout;
    logic          res_valid;
    logic          res_ready;
    logic [AW-1:0] res_data;

    int vecs = 0;
    int miscompares = 0;
    int pa[8];
    int pb[8];

    always #5 clk = ~clk;

    mac_seq_ctrl #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .ACC_WIDTH(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .abort     (abort),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .mac_en    (mac_en),
        .mac_clr   (mac_clr),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_cout  (mac_cout),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data)
    );

    // MAC: registered product, accumulator adds the previous product; clear wins over enable.
    logic [2*DW-1:0] prod_q;
    logic [AW-1:0]   acc_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
            acc_q  <= '0;
        end else if (mac_clr) begin
            prod_q <= '0;
            acc_q  <= '0;
        end else if (mac_en) begin
            prod_q <= mac_a * mac_b;
            acc_q  <= acc_q + AW'(prod_q);
        end
    end
    assign mac_cout = acc_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launches a job of n pairs from pa/pb, optionally stalling gap_len stream cycles
    // before pair gap_at; returns cycles from start to first res_valid plus counters.
    task automatic run_job(input int n, input int gap_at, input int gap_len, input string tag,
                           output int lat, output int rdy_cycles, output int gap_cycles,
                           output int gap_en);
        int  idx;
        int  gap;
        logic done;
        idx = 0; gap = 0; lat = 0; rdy_cycles = 0; gap_cycles = 0; gap_en = 0; done = 1'b0;
        start    = 1'b1;
        len      = LW'(n);
        in_valid = 1'b0;
        step();
        start = 1'b0;
        lat   = 1;
        for (int c = 0; c < 200; c++) begin
            if (res_valid) begin
                done = 1'b1;
                break;
            end
            if (idx < n && !(idx == gap_at && gap < gap_len)) begin
                in_valid = 1'b1;
                a_in     = DW'(pa[idx]);
                b_in     = DW'(pb[idx]);
            end else begin
                in_valid = 1'b0;
                a_in     = '0;
                b_in     = '0;
            end
            #1;
            if (in_ready) begin
                rdy_cycles++;
                if (in_valid) begin
                    idx++;
                end else begin
                    gap_cycles++;
                    if (idx == gap_at) gap++;
                    if (mac_en) gap_en++;
                end
            end
            step();
            lat++;
        end
        in_valid = 1'b0;
        a_in     = '0;
        b_in     = '0;
        chk({tag, "_done"}, 32'(done), 32'd1);
    endtask

    int lat, rdy, gapc, gapen;

    initial begin
        rst_n = 1'b0; start = 1'b0; len = '0; abort = 1'b0;
        in_valid = 1'b1; a_in = 8'd5; b_in = 8'd7; res_ready = 1'b1;
        #2;
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_mac_en",    32'(mac_en),    32'd0);
        chk("rst_mac_clr",   32'(mac_clr),   32'd0);
        chk("rst_mac_a",     32'(mac_a),     32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_data",  32'(res_data),  32'd0);
        in_valid = 1'b0; a_in = '0; b_in = '0;
        step();
        rst_n = 1'b1;
        step();

        // Gap-free len=4: 2+12+30+56
        pa = '{1, 3, 5, 7, 0, 0, 0, 0};
        pb = '{2, 4, 6, 8, 0, 0, 0, 0};
        run_job(4, -1, 0, "j4", lat, rdy, gapc, gapen);
        chk("j4_latency", 32'(lat),      32'd8);
        chk("j4_data",    32'(res_data), 32'd100);
        chk("j4_ready",   32'(rdy),      32'd4);
        step();
        chk("j4_busy_after",  32'(busy),      32'd0);
        chk("j4_valid_after", 32'(res_valid), 32'd0);

        // Same job with a 3-cycle stall before pair 3
        run_job(4, 2, 3, "jgap", lat, rdy, gapc, gapen);
        chk("jgap_latency", 32'(lat),      32'd11);
        chk("jgap_data",    32'(res_data), 32'd100);
        chk("jgap_stalls",  32'(gapc),     32'd3);
        chk("jgap_mac_en",  32'(gapen),    32'd0);
        step();

        // Zero-length job
        run_job(0, -1, 0, "j0", lat, rdy, gapc, gapen);
        chk("j0_latency", 32'(lat),      32'd3);
        chk("j0_data",    32'(res_data), 32'd0);
        chk("j0_ready",   32'(rdy),      32'd0);
        step();

        // Result held under back-pressure, then a fresh job: 6+20, then 81
        res_ready = 1'b0;
        pa = '{2, 4, 0, 0, 0, 0, 0, 0};
        pb = '{3, 5, 0, 0, 0, 0, 0, 0};
        run_job(2, -1, 0, "jh", lat, rdy, gapc, gapen);
        chk("jh_latency", 32'(lat),      32'd6);
        chk("jh_data",    32'(res_data), 32'd26);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("jh_hold_valid", 32'(res_valid), 32'd1);
            chk("jh_hold_data",  32'(res_data),  32'd26);
        end
        res_ready = 1'b1;
        step();
        chk("jh_consumed",   32'(res_valid), 32'd0);
        chk("jh_data_kept",  32'(res_data),  32'd26);
        pa[0] = 9; pb[0] = 9;
        run_job(1, -1, 0, "j81", lat, rdy, gapc, gapen);
        chk("j81_latency", 32'(lat),      32'd5);
        chk("j81_data",    32'(res_data), 32'd81);
        step();

        // Abort in IDLE beats a simultaneous start
        start = 1'b1; abort = 1'b1; len = 8'd3;
        #1;
        chk("idle_abort_clr", 32'(mac_clr), 32'd0);
        step();
        start = 1'b0; abort = 1'b0;
        chk("idle_abort_busy", 32'(busy), 32'd0);
        step();
        chk("idle_abort_busy2", 32'(busy), 32'd0);

        // Abort in STREAM after two pairs
        start = 1'b1; len = 8'd4;
        step();
        start = 1'b0;
        step();
        in_valid = 1'b1; a_in = 8'd1; b_in = 8'd2;
        step();
        a_in = 8'd3; b_in = 8'd4;
        step();
        a_in = 8'd5; b_in = 8'd6; abort = 1'b1;
        #1;
        chk("abort_mac_clr",  32'(mac_clr),  32'd1);
        chk("abort_mac_en",   32'(mac_en),   32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd0);
        step();
        abort = 1'b0; in_valid = 1'b0; a_in = '0; b_in = '0;
        chk("abort_busy_next", 32'(busy),     32'd0);
        chk("abort_no_valid",  32'(res_valid), 32'd0);
        step();
        chk("abort_no_valid2", 32'(res_valid), 32'd0);
        pa[0] = 6; pb[0] = 7;
        run_job(1, -1, 0, "j42", lat, rdy, gapc, gapen);
        chk("j42_data", 32'(res_data), 32'd42);
        step();

        // start held high during RESULT is not queued
        res_ready = 1'b0;
        pa[0] = 3; pb[0] = 3;
        run_job(1, -1, 0, "jq", lat, rdy, gapc, gapen);
        start = 1'b1; len = 8'd2;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("jq_still_result", 32'(res_valid), 32'd1);
        end
        start = 1'b0; res_ready = 1'b1;
        step();
        chk("jq_idle", 32'(busy), 32'd0);
        step();
        chk("jq_no_second_job", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of STREAM
        start = 1'b1; len = 8'd4;
        step();
        start = 1'b0;
        step();
        in_valid = 1'b1; a_in = 8'd9; b_in = 8'd8;
        step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy",      32'(busy),      32'd0);
        chk("mid_rst_in_ready",  32'(in_ready),  32'd0);
        chk("mid_rst_mac_en",    32'(mac_en),    32'd0);
        chk("mid_rst_mac_clr",   32'(mac_clr),   32'd0);
        chk("mid_rst_mac_b",     32'(mac_b),     32'd0);
        chk("mid_rst_res_data",  32'(res_data),  32'd0);
        in_valid = 1'b0; a_in = '0; b_in = '0;
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", vecs);
        $fatal(1, "watchdog expired");
    end

endmodule
